// File: rtl/uart_tx_arbiter.sv
// UART sender arbiter: shares one UART sender between a 1-deep DMA
// slot and a CPU byte FIFO, round-robin when both sides are pending.
module uart_tx_arbiter #(
    parameter int FIFO_DEPTH = 16,
    parameter int BUSY_WAIT  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          dma_req,
    input  logic [7:0]                    dma_data,
    output logic                          dma_pending,
    input  logic                          cpu_push,
    input  logic [7:0]                    cpu_data,
    output logic                          cpu_full,
    output logic [$clog2(FIFO_DEPTH):0]   cpu_count,
    output logic [1:0]                    overflow,
    input  logic                          tx_busy,
    output logic                          tx_start,
    output logic [7:0]                    sdata,
    output logic                          idle
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(BUSY_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      sdata_q, sdata_d;
    logic            rr_q, rr_d;
    logic            slot_q, slot_d;
    logic [7:0]      slot_data_q, slot_data_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      ovf_q, ovf_d;
    logic [7:0]      mem [FIFO_DEPTH];

    logic            grant_dma;
    logic            grant_cpu;
    logic            push_ok;
    logic            cpu_has;

    assign cpu_has     = (count_q != '0);
    assign cpu_full    = (count_q == CW'(FIFO_DEPTH));
    assign push_ok     = cpu_push && !cpu_full;
    assign dma_pending = slot_q;
    assign cpu_count   = count_q;
    assign overflow    = ovf_q;
    assign sdata       = sdata_q;
    assign idle        = (state_q == IDLE) && !slot_q && !cpu_has;

    // Arbitration and sender handshake sequencing (rr_q=0 means DMA next)
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        sdata_d   = sdata_q;
        rr_d      = rr_q;
        grant_dma = 1'b0;
        grant_cpu = 1'b0;
        tx_start  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((slot_q || cpu_has) && !tx_busy) begin
                    if (slot_q && cpu_has) begin
                        grant_dma = !rr_q;
                        grant_cpu = rr_q;
                        rr_d      = !rr_q;
                    end else begin
                        grant_dma = slot_q;
                        grant_cpu = cpu_has;
                    end
                    sdata_d = grant_dma ? slot_data_q : mem[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                tx_start = 1'b1;
                timer_d  = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TW'(BUSY_WAIT - 1)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // DMA slot, FIFO pointers/count and sticky overrun flags
    always_comb begin
        slot_d      = slot_q;
        slot_data_d = slot_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        if (grant_dma) begin
            slot_d = 1'b0;
        end
        if (dma_req && (!slot_q || grant_dma)) begin
            slot_d      = 1'b1;
            slot_data_d = dma_data;
        end
        if (dma_req && slot_q && !grant_dma) begin
            ovf_d[0] = 1'b1;
        end
        if (cpu_push && cpu_full) begin
            ovf_d[1] = 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (grant_cpu) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, grant_cpu})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            sdata_q     <= '0;
            rr_q        <= 1'b0;
            slot_q      <= 1'b0;
            slot_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            sdata_q     <= sdata_d;
            rr_q        <= rr_d;
            slot_q      <= slot_d;
            slot_data_q <= slot_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    // FIFO storage; contents are meaningless until written, so no reset
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= cpu_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: sender model, scoreboard of expected bytes,
// table-driven FIFO fill and hand-written corner sequences.
module tb_uart_tx_arbiter;

    localparam int DEPTH    = 16;
    localparam int BW       = 4;
    localparam int BUSY_LEN = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       dma_req;
    logic [7:0] dma_data;
    logic       dma_pending;
    logic       cpu_push;
    logic [7:0] cpu_data;
    logic       cpu_full;
    logic [4:0] cpu_count;
    logic [1:0] overflow;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] sdata;
    logic       idle;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int cyc = 0;
    int starts = 0;
    int last_start = 0;
    int gap = 0;
    logic busy_hold = 1'b0;
    logic mute = 1'b0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] d;
        logic [4:0] cnt;
        logic       full;
        logic [1:0] ovf;
    } vec_t;
    vec_t tbl[DEPTH + 1];

    uart_tx_arbiter #(.FIFO_DEPTH(DEPTH), .BUSY_WAIT(BW)) dut (
        .clock(clock), .reset(reset),
        .dma_req(dma_req), .dma_data(dma_data), .dma_pending(dma_pending),
        .cpu_push(cpu_push), .cpu_data(cpu_data), .cpu_full(cpu_full),
        .cpu_count(cpu_count), .overflow(overflow),
        .tx_busy(tx_busy), .tx_start(tx_start), .sdata(sdata), .idle(idle)
    );

    always #5 clock = ~clock;

    assign tx_busy = busy_hold || (busy_cnt != 0);

    always @(posedge clock or posedge reset) begin
        if (reset) busy_cnt <= 0;
        else if (tx_start && !mute) busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (!reset && tx_start) begin
                starts++;
                gap = cyc - last_start;
                last_start = cyc;
                if (exp_q.size() == 0) begin
                    check("tx_start_unexpected", 32'(sdata), 32'h100);
                end else begin
                    e = exp_q.pop_front();
                    check("sdata_order", 32'(sdata), 32'(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic push_cpu(logic [7:0] d, bit expect_sent);
        if (expect_sent) exp_q.push_back(d);
        cpu_push = 1'b1;
        cpu_data = d;
        tick();
        cpu_push = 1'b0;
    endtask

    task automatic send_dma(logic [7:0] d, bit expect_sent);
        if (expect_sent) exp_q.push_back(d);
        dma_req  = 1'b1;
        dma_data = d;
        tick();
        dma_req = 1'b0;
    endtask

    task automatic wait_drain(string name, int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = idle && busy_cnt == 0 && exp_q.size() == 0;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        bit seen;
        reset = 1'b1;
        dma_req = 1'b0;
        dma_data = '0;
        cpu_push = 1'b0;
        cpu_data = '0;
        repeat (2) tick();
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_sdata", 32'(sdata), 0);
        check("rst_pending", 32'(dma_pending), 0);
        check("rst_count", 32'(cpu_count), 0);
        check("rst_full", 32'(cpu_full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_idle", 32'(idle), 1);
        reset = 1'b0;
        tick();

        // 1: DMA byte, 2-cycle latency
        s0 = starts;
        exp_q.push_back(8'h99);
        dma_req = 1'b1;
        dma_data = 8'h99;
        tick();
        dma_req = 1'b0;
        check("t1_start_early", 32'(tx_start), 0);
        check("t1_pending", 32'(dma_pending), 1);
        check("t1_not_idle", 32'(idle), 0);
        tick();
        check("t1_start", 32'(tx_start), 1);
        check("t1_sdata", 32'(sdata), 32'h99);
        check("t1_pending_clr", 32'(dma_pending), 0);
        wait_drain("t1_drain", 100);
        check("t1_idle", 32'(idle), 1);
        check("t1_starts", 32'(starts - s0), 1);

        // 2: three CPU bytes back-to-back
        s0 = starts;
        push_cpu(8'h41, 1);
        push_cpu(8'h42, 1);
        push_cpu(8'h43, 1);
        wait_drain("t2_drain", 200);
        check("t2_starts", 32'(starts - s0), 3);

        // 3a: rr=DMA -> aa,10,11
        do_reset();
        busy_hold = 1'b1;
        exp_q.push_back(8'haa);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        push_cpu(8'h10, 0);
        push_cpu(8'h11, 0);
        send_dma(8'haa, 0);
        busy_hold = 1'b0;
        wait_drain("t3a_drain", 200);

        // 3b: rr now CPU -> 10,aa,11
        busy_hold = 1'b1;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'haa);
        exp_q.push_back(8'h11);
        push_cpu(8'h10, 0);
        push_cpu(8'h11, 0);
        send_dma(8'haa, 0);
        busy_hold = 1'b0;
        wait_drain("t3b_drain", 200);

        // 4: fill FIFO past full (table-driven)
        for (int i = 0; i <= DEPTH; i++) begin
            tbl[i].d    = 8'ha0 + 8'(i);
            tbl[i].cnt  = (i < DEPTH) ? 5'(i + 1) : 5'(DEPTH);
            tbl[i].full = (i >= DEPTH - 1);
            tbl[i].ovf  = (i >= DEPTH) ? 2'b10 : 2'b00;
        end
        do_reset();
        s0 = starts;
        busy_hold = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            push_cpu(tbl[i].d, i < DEPTH);
            check($sformatf("t4_count_%0d", i), 32'(cpu_count), 32'(tbl[i].cnt));
            check($sformatf("t4_full_%0d", i), 32'(cpu_full), 32'(tbl[i].full));
            check($sformatf("t4_ovf_%0d", i), 32'(overflow), 32'(tbl[i].ovf));
        end
        cpu_push = 1'b1;
        cpu_data = 8'hee;
        busy_hold = 1'b0;
        tick();
        cpu_push = 1'b0;
        check("t4_pushpop_count", 32'(cpu_count), DEPTH - 1);
        check("t4_pushpop_full", 32'(cpu_full), 0);
        wait_drain("t4_drain", 1000);
        check("t4_starts", 32'(starts - s0), DEPTH);
        check("t4_ovf_sticky", 32'(overflow), 32'h2);

        // 5: sender never goes busy -> timeout, next byte still sent
        mute = 1'b1;
        s0 = starts;
        push_cpu(8'h55, 1);
        push_cpu(8'h66, 1);
        wait_drain("t5_drain", 100);
        check("t5_starts", 32'(starts - s0), 2);
        check("t5_gap", 32'(gap), BW + 2);
        mute = 1'b0;

        // 6: reset during WAIT_DONE with 3 bytes queued
        push_cpu(8'h71, 1);
        push_cpu(8'h72, 0);
        push_cpu(8'h73, 0);
        push_cpu(8'h74, 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (tx_busy) seen = 1'b1;
            else tick();
        end
        check("t6_busy_seen", 32'(seen), 1);
        tick();
        check("t6_count_pre", 32'(cpu_count), 3);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("t6_tx_start", 32'(tx_start), 0);
        check("t6_count", 32'(cpu_count), 0);
        check("t6_pending", 32'(dma_pending), 0);
        check("t6_ovf", 32'(overflow), 0);
        check("t6_idle", 32'(idle), 1);
        tick();
        reset = 1'b0;
        s0 = starts;
        repeat (30) tick();
        check("t6_no_start", 32'(starts - s0), 0);

        // 7: DMA overrun, then refill in the grant cycle
        busy_hold = 1'b1;
        send_dma(8'h99, 1);
        send_dma(8'haa, 0);
        check("t7_ovf0", 32'(overflow), 1);
        exp_q.push_back(8'hbb);
        dma_req = 1'b1;
        dma_data = 8'hbb;
        busy_hold = 1'b0;
        tick();
        dma_req = 1'b0;
        check("t7_refill_pending", 32'(dma_pending), 1);
        check("t7_refill_ovf", 32'(overflow), 1);
        wait_drain("t7_drain", 200);

        // 8: reset during the tx_start cycle drops it at once
        push_cpu(8'h80, 1);
        tick();
        check("t8_start", 32'(tx_start), 1);
        reset = 1'b1;
        #1;
        check("t8_start_rst", 32'(tx_start), 0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        check("t8_idle", 32'(idle), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
